// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, DMA and memory port signal bundle for the arbiter
interface mem_bus_arbiter_if;
    logic        i_cpu_rd;
    logic        i_cpu_wr;
    logic [15:0] i_cpu_addr;
    logic [15:0] i_cpu_wdata;
    logic [15:0] o_cpu_rdata;
    logic        o_cpu_stall;
    logic        o_cpu_done;

    logic        i_dma_req;
    logic        i_dma_we;
    logic [15:0] i_dma_addr;
    logic [15:0] i_dma_wdata;
    logic [15:0] o_dma_rdata;
    logic        o_dma_ack;

    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] i_mem_rdata;

    logic        o_err;

    // Arbiter side
    modport slave (
        input  i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
        output o_cpu_rdata, o_cpu_stall, o_cpu_done,
        input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
        output o_dma_rdata, o_dma_ack,
        output o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
        input  i_mem_rdata,
        output o_err
    );

    // Requester / memory model side
    modport master (
        output i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_rdata, o_cpu_stall, o_cpu_done,
        output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
        input  o_dma_rdata, o_dma_ack,
        input  o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
        output i_mem_rdata,
        input  o_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA shared memory port arbiter with wait states and starvation limit
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mem_bus_arbiter_if.slave    bus
);
    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_LD = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_we;
    logic        owner_dma;
    logic [3:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic [15:0] cpu_rdata;
    logic [15:0] dma_rdata;
    logic        err_q;

    logic cpu_req;
    logic cpu_win;
    logic dma_win;
    logic in_acc;
    logic cpu_done;

    assign cpu_req  = bus.i_cpu_rd | bus.i_cpu_wr;
    // CPU wins unless the DMA has been passed over STARVE_LIMIT times in a row
    assign cpu_win  = cpu_req && (!bus.i_dma_req || (starve_cnt < STARVE_LD));
    assign dma_win  = !cpu_win && bus.i_dma_req;
    assign in_acc   = (state_q == CPU_ACC) || (state_q == DMA_ACC);
    assign cpu_done = (state_q == RESP) && !owner_dma;

    // State register; asynchronous reset drops the access phase immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate in IDLE, count down the access, one response cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    state_d = CPU_ACC;
                end else if (dma_win) begin
                    state_d = DMA_ACC;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (wait_cnt == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latching, wait/starve counters, read capture and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            owner_dma  <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            err_q      <= 1'b0;
        end else if ((state_q == IDLE) && cpu_win) begin
            lat_addr  <= bus.i_cpu_addr;
            lat_wdata <= bus.i_cpu_wdata;
            // Conflicting rd+wr is flagged and carried out as a write
            lat_we    <= bus.i_cpu_wr;
            owner_dma <= 1'b0;
            wait_cnt  <= WAIT_LD;
            if (bus.i_dma_req) begin
                starve_cnt <= (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
            if (bus.i_cpu_rd && bus.i_cpu_wr) begin
                err_q <= 1'b1;
            end
        end else if ((state_q == IDLE) && dma_win) begin
            lat_addr   <= bus.i_dma_addr;
            lat_wdata  <= bus.i_dma_wdata;
            lat_we     <= bus.i_dma_we;
            owner_dma  <= 1'b1;
            wait_cnt   <= WAIT_LD;
            starve_cnt <= '0;
        end else if (in_acc) begin
            if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else if (!lat_we) begin
                if (owner_dma) begin
                    dma_rdata <= bus.i_mem_rdata;
                end else begin
                    cpu_rdata <= bus.i_mem_rdata;
                end
            end
        end
    end

    assign bus.o_mem_addr  = lat_addr;
    assign bus.o_mem_wdata = lat_wdata;
    assign bus.o_mem_rd    = in_acc && !lat_we;
    assign bus.o_mem_wr    = in_acc && lat_we;
    assign bus.o_cpu_rdata = cpu_rdata;
    assign bus.o_dma_rdata = dma_rdata;
    assign bus.o_cpu_done  = cpu_done;
    assign bus.o_dma_ack   = (state_q == RESP) && owner_dma;
    assign bus.o_cpu_stall = cpu_req && !cpu_done;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if bus1();
    mem_bus_arbiter_if bus0();

    mem_bus_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(4)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'h0100) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign bus1.i_mem_rdata = mem_f(bus1.o_mem_addr);
    assign bus0.i_mem_rdata = mem_f(bus0.o_mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  gseq [10];
        logic [7:0]  gexp [10];
        logic [15:0] a0 [3];
        logic [15:0] d0 [3];
        int          ng;
        logic        prev_rd;

        gexp = '{"C", "C", "C", "C", "D", "C", "C", "C", "C", "D"};
        a0   = '{16'h0011, 16'h0222, 16'h3333};
        d0   = '{16'h4B5A, 16'h7858, 16'h6969};
        for (int i = 0; i < 10; i++) gseq[i] = 8'h00;

        bus1.i_cpu_rd = 0; bus1.i_cpu_wr = 0; bus1.i_cpu_addr = 0; bus1.i_cpu_wdata = 0;
        bus1.i_dma_req = 0; bus1.i_dma_we = 0; bus1.i_dma_addr = 0; bus1.i_dma_wdata = 0;
        bus0.i_cpu_rd = 0; bus0.i_cpu_wr = 0; bus0.i_cpu_addr = 0; bus0.i_cpu_wdata = 0;
        bus0.i_dma_req = 0; bus0.i_dma_we = 0; bus0.i_dma_addr = 0; bus0.i_dma_wdata = 0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_mem_rd", 16'(bus1.o_mem_rd), 16'h0);
        chk("rst_mem_wr", 16'(bus1.o_mem_wr), 16'h0);
        chk("rst_stall", 16'(bus1.o_cpu_stall), 16'h0);
        chk("rst_done", 16'(bus1.o_cpu_done), 16'h0);
        chk("rst_ack", 16'(bus1.o_dma_ack), 16'h0);
        chk("rst_err", 16'(bus1.o_err), 16'h0);
        chk("rst_cpu_rdata", bus1.o_cpu_rdata, 16'h0000);
        chk("rst_dma_rdata", bus1.o_dma_rdata, 16'h0000);
        chk("rst_mem_addr", bus1.o_mem_addr, 16'h0000);
        rst_n = 1'b1;
        tick();

        // CPU read, WAIT_CYCLES=1
        bus1.i_cpu_rd = 1; bus1.i_cpu_addr = 16'h0100;
        #1;
        chk("t1_c0_stall", 16'(bus1.o_cpu_stall), 16'h1);
        chk("t1_c0_rd", 16'(bus1.o_mem_rd), 16'h0);
        tick();
        chk("t1_c1_rd", 16'(bus1.o_mem_rd), 16'h1);
        chk("t1_c1_addr", bus1.o_mem_addr, 16'h0100);
        chk("t1_c1_stall", 16'(bus1.o_cpu_stall), 16'h1);
        tick();
        chk("t1_c2_rd", 16'(bus1.o_mem_rd), 16'h1);
        chk("t1_c2_done", 16'(bus1.o_cpu_done), 16'h0);
        tick();
        chk("t1_c3_rd", 16'(bus1.o_mem_rd), 16'h0);
        chk("t1_c3_done", 16'(bus1.o_cpu_done), 16'h1);
        chk("t1_c3_stall", 16'(bus1.o_cpu_stall), 16'h0);
        chk("t1_rdata", bus1.o_cpu_rdata, 16'hBEEF);
        bus1.i_cpu_rd = 0;
        tick();
        chk("t1_c4_done", 16'(bus1.o_cpu_done), 16'h0);
        chk("t1_c4_stall", 16'(bus1.o_cpu_stall), 16'h0);

        // DMA write with CPU idle
        bus1.i_dma_req = 1; bus1.i_dma_we = 1; bus1.i_dma_addr = 16'h2000; bus1.i_dma_wdata = 16'h1234;
        tick();
        chk("t2_wr1", 16'(bus1.o_mem_wr), 16'h1);
        chk("t2_addr", bus1.o_mem_addr, 16'h2000);
        chk("t2_wdata", bus1.o_mem_wdata, 16'h1234);
        chk("t2_rd1", 16'(bus1.o_mem_rd), 16'h0);
        tick();
        chk("t2_wr2", 16'(bus1.o_mem_wr), 16'h1);
        chk("t2_ack_early", 16'(bus1.o_dma_ack), 16'h0);
        tick();
        chk("t2_wr3", 16'(bus1.o_mem_wr), 16'h0);
        chk("t2_ack", 16'(bus1.o_dma_ack), 16'h1);
        chk("t2_dma_rdata", bus1.o_dma_rdata, 16'h0000);
        chk("t2_cpu_rdata", bus1.o_cpu_rdata, 16'hBEEF);
        bus1.i_dma_req = 0; bus1.i_dma_we = 0;
        tick();
        chk("t2_ack_off", 16'(bus1.o_dma_ack), 16'h0);

        // Starvation limit: both request continuously
        bus1.i_cpu_rd = 1; bus1.i_cpu_addr = 16'h0300;
        bus1.i_dma_req = 1; bus1.i_dma_we = 0; bus1.i_dma_addr = 16'h4000;
        ng = 0;
        prev_rd = 1'b0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            tick();
            if (bus1.o_mem_rd && !prev_rd) begin
                gseq[ng] = (bus1.o_mem_addr == 16'h4000) ? "D" : "C";
                if (bus1.o_mem_addr == 16'h4000)
                    chk("t3_stall_dma", 16'(bus1.o_cpu_stall), 16'h1);
                ng++;
            end
            prev_rd = bus1.o_mem_rd;
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_grant%0d", i), 16'(gseq[i]), 16'(gexp[i]));
        bus1.i_cpu_rd = 0; bus1.i_dma_req = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("t3_dma_rdata", bus1.o_dma_rdata, 16'h5A1A);
        chk("t3_idle_rd", 16'(bus1.o_mem_rd), 16'h0);

        // WAIT_CYCLES=0 back-to-back CPU reads
        bus0.i_cpu_rd = 1; bus0.i_cpu_addr = a0[0];
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t4_rd_%0d", k), 16'(bus0.o_mem_rd), 16'h1);
            chk($sformatf("t4_addr_%0d", k), bus0.o_mem_addr, a0[k]);
            tick();
            chk($sformatf("t4_rd_off_%0d", k), 16'(bus0.o_mem_rd), 16'h0);
            chk($sformatf("t4_done_%0d", k), 16'(bus0.o_cpu_done), 16'h1);
            chk($sformatf("t4_rdata_%0d", k), bus0.o_cpu_rdata, d0[k]);
            if (k < 2) bus0.i_cpu_addr = a0[k + 1];
            else bus0.i_cpu_rd = 0;
            tick();
            chk($sformatf("t4_idle_done_%0d", k), 16'(bus0.o_cpu_done), 16'h0);
            chk($sformatf("t4_idle_stall_%0d", k), 16'(bus0.o_cpu_stall), (k < 2) ? 16'h1 : 16'h0);
        end

        // Conflicting rd+wr, then reset mid-access
        bus1.i_cpu_rd = 1; bus1.i_cpu_wr = 1; bus1.i_cpu_addr = 16'h0500; bus1.i_cpu_wdata = 16'h5555;
        tick();
        chk("t5_err", 16'(bus1.o_err), 16'h1);
        chk("t5_wr", 16'(bus1.o_mem_wr), 16'h1);
        chk("t5_rd", 16'(bus1.o_mem_rd), 16'h0);
        chk("t5_wdata", bus1.o_mem_wdata, 16'h5555);
        tick();
        chk("t5_err_sticky", 16'(bus1.o_err), 16'h1);
        chk("t5_wr2", 16'(bus1.o_mem_wr), 16'h1);
        rst_n = 1'b0;
        bus1.i_cpu_rd = 0; bus1.i_cpu_wr = 0;
        #1;
        chk("t5_rst_wr", 16'(bus1.o_mem_wr), 16'h0);
        chk("t5_rst_err", 16'(bus1.o_err), 16'h0);
        chk("t5_rst_done", 16'(bus1.o_cpu_done), 16'h0);
        chk("t5_rst_stall", 16'(bus1.o_cpu_stall), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_post_wr", 16'(bus1.o_mem_wr), 16'h0);
        chk("t5_post_rd", 16'(bus1.o_mem_rd), 16'h0);
        chk("t5_post_err", 16'(bus1.o_err), 16'h0);

        // DMA drops its request mid-access; pending CPU gets the next grant
        bus1.i_dma_req = 1; bus1.i_dma_we = 0; bus1.i_dma_addr = 16'h6000;
        tick();
        chk("t6_rd", 16'(bus1.o_mem_rd), 16'h1);
        chk("t6_addr", bus1.o_mem_addr, 16'h6000);
        bus1.i_dma_req = 0;
        bus1.i_cpu_rd = 1; bus1.i_cpu_addr = 16'h0700;
        tick();
        chk("t6_rd2", 16'(bus1.o_mem_rd), 16'h1);
        chk("t6_addr2", bus1.o_mem_addr, 16'h6000);
        chk("t6_stall_dma", 16'(bus1.o_cpu_stall), 16'h1);
        tick();
        chk("t6_ack", 16'(bus1.o_dma_ack), 16'h1);
        chk("t6_dma_rdata", bus1.o_dma_rdata, 16'h5A3A);
        chk("t6_stall_resp", 16'(bus1.o_cpu_stall), 16'h1);
        tick();
        chk("t6_idle_rd", 16'(bus1.o_mem_rd), 16'h0);
        chk("t6_ack_off", 16'(bus1.o_dma_ack), 16'h0);
        tick();
        chk("t6_cpu_rd", 16'(bus1.o_mem_rd), 16'h1);
        chk("t6_cpu_addr", bus1.o_mem_addr, 16'h0700);
        tick();
        tick();
        chk("t6_cpu_done", 16'(bus1.o_cpu_done), 16'h1);
        chk("t6_cpu_rdata", bus1.o_cpu_rdata, 16'h5A5D);
        bus1.i_cpu_rd = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
